// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: ALU op codes, 6502 opcodes, FSM states,
// decode record and the carry-flag update rule.
package alu_seq_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    localparam logic [7:0] OP_ADC = 8'h69;
    localparam logic [7:0] OP_SBC = 8'hE9;
    localparam logic [7:0] OP_AND = 8'h29;
    localparam logic [7:0] OP_ORA = 8'h09;
    localparam logic [7:0] OP_EOR = 8'h49;
    localparam logic [7:0] OP_ASL = 8'h0A;
    localparam logic [7:0] OP_LSR = 8'h4A;
    localparam logic [7:0] OP_LDA = 8'hA9;
    localparam logic [7:0] OP_SEC = 8'h38;
    localparam logic [7:0] OP_CLC = 8'h18;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_EXEC1 = 2'd1;
    localparam state_t ST_EXEC2 = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam logic [2:0] CK_KEEP = 3'd0;
    localparam logic [2:0] CK_ADC  = 3'd1;
    localparam logic [2:0] CK_SBC  = 3'd2;
    localparam logic [2:0] CK_ASL  = 3'd3;
    localparam logic [2:0] CK_LSR  = 3'd4;
    localparam logic [2:0] CK_SET  = 3'd5;
    localparam logic [2:0] CK_CLR  = 3'd6;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       uses_alu;
        logic [2:0] carry_kind;
        logic       load_zero;
        logic       illegal;
    } dec_t;

    // The ALU reports borrow on subtract, so SBC inverts it to get 6502 carry.
    function automatic logic next_carry(input logic [2:0] kind, input logic c1,
                                        input logic c2, input logic lsb, input logic c_old);
        logic c;
        c = c_old;
        case (kind)
            CK_ADC:  c = c1 | c2;
            CK_SBC:  c = ~(c1 | c2);
            CK_ASL:  c = c1;
            CK_LSR:  c = lsb;
            CK_SET:  c = 1'b1;
            CK_CLR:  c = 1'b0;
            default: c = c_old;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Opcode to decode-record mapping; purely combinational, zero latency, no flow control.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [7:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec          = '0;
        dec.uses_alu = 1'b1;
        case (opcode)
            OP_ADC: begin dec.alu_op = ALU_ADD; dec.carry_kind = CK_ADC; end
            OP_SBC: begin dec.alu_op = ALU_SUB; dec.carry_kind = CK_SBC; end
            OP_AND: dec.alu_op = ALU_AND;
            OP_ORA: dec.alu_op = ALU_OR;
            OP_EOR: dec.alu_op = ALU_XOR;
            OP_ASL: begin dec.alu_op = ALU_SHL; dec.carry_kind = CK_ASL; end
            OP_LSR: begin dec.alu_op = ALU_SHR; dec.carry_kind = CK_LSR; end
            OP_LDA: begin dec.alu_op = ALU_OR;  dec.load_zero  = 1'b1;   end
            OP_SEC: begin dec.uses_alu = 1'b0; dec.carry_kind = CK_SET; end
            OP_CLC: begin dec.uses_alu = 1'b0; dec.carry_kind = CK_CLR; end
            default: begin dec.uses_alu = 1'b0; dec.illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues 6502 immediate/accumulator ops to an external 8-bit ALU, owning acc and C/Z.
// Response 1-3 cycles after accept; one op in flight, response held until rsp_ready.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_opcode,
    input  logic [7:0] cmd_operand,
    output logic [7:0] alu_operand1,
    output logic [7:0] alu_operand2,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_acc,
    output logic       rsp_c,
    output logic       rsp_z,
    output logic       rsp_err
);

    dec_t       dec_in;
    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d, operand_q, operand_d, res1_q, res1_d;
    logic [2:0] op_q, op_d, kind_q, kind_d;
    logic       load_zero_q, load_zero_d;
    logic       c_q, c_d, z_q, z_d, err_q, err_d, c1_q, c1_d;
    logic       need_pass2;
    logic       unused_alu_zero;

    assign unused_alu_zero = alu_zero;

    alu_seq_decode u_decode (
        .opcode (cmd_opcode),
        .dec    (dec_in)
    );

    // ALU has no carry-in: a second +/-1 pass stands in for it.
    assign need_pass2 = ((kind_q == CK_ADC) && c_q) || ((kind_q == CK_SBC) && !c_q);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        operand_d    = operand_q;
        res1_d       = res1_q;
        op_d         = op_q;
        kind_d       = kind_q;
        load_zero_d  = load_zero_q;
        c_d          = c_q;
        z_d          = z_q;
        err_d        = err_q;
        c1_d         = c1_q;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_operand1 = 8'h00;
        alu_operand2 = 8'h00;
        alu_op       = ALU_ADD;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d        = dec_in.alu_op;
                    kind_d      = dec_in.carry_kind;
                    load_zero_d = dec_in.load_zero;
                    operand_d   = cmd_operand;
                    if (dec_in.uses_alu) begin
                        state_d = ST_EXEC1;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = dec_in.illegal;
                        c_d     = next_carry(dec_in.carry_kind, 1'b0, 1'b0, 1'b0, c_q);
                    end
                end
            end
            ST_EXEC1: begin
                alu_operand1 = load_zero_q ? 8'h00 : acc_q;
                alu_operand2 = operand_q;
                alu_op       = op_q;
                if (need_pass2) begin
                    res1_d  = alu_result;
                    c1_d    = alu_carry;
                    state_d = ST_EXEC2;
                end else begin
                    acc_d   = alu_result;
                    z_d     = (alu_result == 8'h00);
                    c_d     = next_carry(kind_q, alu_carry, 1'b0, acc_q[0], c_q);
                    state_d = ST_RESP;
                end
            end
            ST_EXEC2: begin
                alu_operand1 = res1_q;
                alu_operand2 = 8'h01;
                alu_op       = (kind_q == CK_SBC) ? ALU_SUB : ALU_ADD;
                acc_d        = alu_result;
                z_d          = (alu_result == 8'h00);
                c_d          = next_carry(kind_q, c1_q, alu_carry, acc_q[0], c_q);
                state_d      = ST_RESP;
            end
            default: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= ACC_RESET;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            err_q       <= 1'b0;
            operand_q   <= 8'h00;
            res1_q      <= 8'h00;
            c1_q        <= 1'b0;
            op_q        <= ALU_ADD;
            kind_q      <= CK_KEEP;
            load_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            z_q         <= z_d;
            err_q       <= err_d;
            operand_q   <= operand_d;
            res1_q      <= res1_d;
            c1_q        <= c1_d;
            op_q        <= op_d;
            kind_q      <= kind_d;
            load_zero_q <= load_zero_d;
        end
    end

    assign rsp_acc = acc_q;
    assign rsp_c   = c_q;
    assign rsp_z   = z_q;
    assign rsp_err = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_opcode, cmd_operand;
    logic [7:0] alu_operand1, alu_operand2, alu_result;
    logic [2:0] alu_op;
    logic       alu_carry, alu_zero;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_acc;
    logic       rsp_c, rsp_z, rsp_err;

    alu_sequencer #(.ACC_RESET(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_operand  (cmd_operand),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_acc      (rsp_acc),
        .rsp_c        (rsp_c),
        .rsp_z        (rsp_z),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference ALU: carry is carry-out on add, borrow on sub, msb-out on shl.
    always_comb begin
        alu_carry = 1'b0;
        case (alu_op)
            ALU_ADD: {alu_carry, alu_result} = {1'b0, alu_operand1} + {1'b0, alu_operand2};
            ALU_SUB: begin
                alu_result = alu_operand1 - alu_operand2;
                alu_carry  = (alu_operand1 < alu_operand2);
            end
            ALU_AND: alu_result = alu_operand1 & alu_operand2;
            ALU_OR:  alu_result = alu_operand1 | alu_operand2;
            ALU_XOR: alu_result = alu_operand1 ^ alu_operand2;
            ALU_NOT: alu_result = ~alu_operand1;
            ALU_SHL: {alu_carry, alu_result} = {alu_operand1, 1'b0};
            default: alu_result = alu_operand1 >> 1;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] acc;
        logic       c, z, err;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    logic vld_prev = 1'b0;
    int   rise_cyc = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rsp_valid && !vld_prev) rise_cyc = cyc;
        vld_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("stale_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_acc_c_z_err", {rsp_acc, rsp_c, rsp_z, rsp_err},
                      {mon_e.acc, mon_e.c, mon_e.z, mon_e.err});
                check("rsp_latency", rise_cyc - mon_e.acc_cyc, mon_e.lat);
            end
        end
    end

    // Called and returning at posedge+1; accept happens at the edge ending cycle acc_cyc.
    task automatic send(input logic [7:0] op, input logic [7:0] opd, input logic [7:0] eacc,
                        input logic ec, input logic ez, input logic eerr, input int lat,
                        input bit push);
        int   waited;
        exp_t e;
        waited      = 0;
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_operand = opd;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            if (push) begin
                e.acc = eacc; e.c = ec; e.z = ez; e.err = eerr;
                e.lat = lat;  e.acc_cyc = cyc;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        int waited;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_operand = 8'h00; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu_drive", {alu_op, alu_operand1, alu_operand2}, 0);
        check("rst_acc_c_z", {rsp_acc, rsp_c, rsp_z}, 0);
        @(posedge clk); #1;

        //     op      opd    acc    C     Z     err  lat
        send(OP_CLC, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_LDA, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 2, 1);
        send(OP_SEC, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1, 1);
        send(OP_ADC, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3, 1);
        send(OP_SEC, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1);
        send(OP_LDA, 8'h05, 8'h05, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_SBC, 8'h06, 8'hFF, 1'b0, 1'b0, 1'b0, 2, 1);
        send(OP_CLC, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_LDA, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 2, 1);
        send(OP_SBC, 8'h01, 8'h0E, 1'b1, 1'b0, 1'b0, 3, 1);
        send(OP_LDA, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_LSR, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 2, 1);
        send(OP_LDA, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_ASL, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_LDA, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_SEC, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0, 1, 1);
        send(8'hFF,  8'h55, 8'h3C, 1'b1, 1'b0, 1'b1, 1, 1);
        send(OP_ORA, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_EOR, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b0, 2, 1);
        send(OP_LDA, 8'hF3, 8'hF3, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_AND, 8'h0F, 8'h03, 1'b1, 1'b0, 1'b0, 2, 1);

        // Stall the response and confirm it is held with the command side closed.
        rsp_ready = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("hold_rsp_arrived", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_acc", rsp_acc, 8'h03);
            check("hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("resume_cmd_ready", cmd_ready, 1);
        send(OP_ORA, 8'h80, 8'h83, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_CLC, 8'h00, 8'h83, 1'b0, 1'b0, 1'b0, 1, 1);
        send(OP_ADC, 8'h90, 8'h13, 1'b1, 1'b0, 1'b0, 2, 1);
        send(OP_SEC, 8'h00, 8'h13, 1'b1, 1'b0, 1'b0, 1, 1);

        // Two-pass ADC interrupted by reset while in its second pass.
        send(OP_ADC, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk); #1;
        check("exec2_operand2", alu_operand2, 8'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_acc_c_z", {rsp_acc, rsp_c, rsp_z}, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        send(OP_LDA, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2, 1);
        send(OP_ADC, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 2, 1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check("drain_queue", exp_q.size(), 0);
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
